float_conv_arbiter: RTL and testbench

FLOAT_CONV_ARBITER -- requirements
Module: float_conv_arbiter

---
 rtl/float_conv_arbiter_pkg.sv | 13 +
 rtl/float_conv_arbiter_rr_pick.sv | 22 ++
 rtl/float_conv_arbiter.sv | 108 ++++++++++
 tb/tb_float_conv_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_conv_arbiter_pkg.sv
// Shared FPU constants and helpers for the int-to-float converter arbiter.
package float_conv_arbiter_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int LAT_DEFAULT  = 2;
  localparam int DATA_W       = 32;

  // Index width that stays legal (>= 1 bit) even for a single requester.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/float_conv_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant of the first eligible requester found
// searching upward from ptr, wrapping from N-1 back to 0.
module rr_pick
  import float_conv_arbiter_pkg::*;
#(
  parameter int N  = NREQ_DEFAULT,
  parameter int PW = clog2_min1(NREQ_DEFAULT)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rot_elig;
  logic [N-1:0] rot_grant;

  // Rotate so that ptr lands on bit 0, pick the lowest set bit, rotate back.
  assign rot_elig  = N'({eligible, eligible} >> ptr);
  assign rot_grant = rot_elig & (~rot_elig + N'(1));
  assign grant     = N'(({rot_grant, rot_grant} << ptr) >> N);

endmodule

// File: rtl/float_conv_arbiter.sv
// Shares one external LAT-cycle int-to-float converter between NREQ
// requesters. Accepts at most one operand per cycle (round-robin), tracks the
// owner of every in-flight operation in a tag shift pipeline and returns the
// converted value to that owner LAT+2 cycles after acceptance.
module float_conv_arbiter
  import float_conv_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int LAT  = LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        busy,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic [DATA_W-1:0]      conv_a,
  output logic                   conv_start,
  input  logic [DATA_W-1:0]      conv_value
);

  localparam int IDW = clog2_min1(NREQ);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_next;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   grant;
  logic              any_grant;
  logic [IDW-1:0]    grant_id;
  logic [DATA_W-1:0] grant_data;
  logic [NREQ-1:0]   done_mask;
  tag_t              tag_pipe [LAT+1];

  // A requester with an operation in flight is never offered a new slot.
  assign eligible = req_valid & ~busy;

  rr_pick #(
    .N  (NREQ),
    .PW (IDW)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

  // Nothing is accepted while reset is held, even though busy is clear then.
  assign req_ready = reset_n ? grant : '0;
  assign any_grant = |req_ready;
  assign ptr_next  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  // Final pipeline stage names the requester whose result arrives this cycle.
  assign done_mask = tag_pipe[LAT].valid ? (NREQ'(1) << tag_pipe[LAT].id) : '0;

  // One-hot to index/operand: OR-reduce the granted lane.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant_id   = '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        grant_id   = grant_id | IDW'(i);
        grant_data = grant_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Issue to the converter, track owners, and return results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      busy       <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      conv_a     <= '0;
      conv_start <= 1'b0;
      // NOTE: the tag pipeline is a handful of flops, not a RAM, so it is
      // cleared outright; that is what drops in-flight work on reset.
      for (int s = 0; s <= LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every stage reading pre-edge values.
      conv_start  <= any_grant;
      tag_pipe[0] <= '{valid: any_grant, id: grant_id};
      for (int s = 1; s <= LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      if (any_grant) begin
        conv_a <= grant_data;
        ptr    <= ptr_next;
      end
      resp_valid <= done_mask;
      if (tag_pipe[LAT].valid) begin
        resp_data <= conv_value;
      end
      // Clearing and setting never hit the same bit: a grant needs busy low.
      busy <= (busy & ~done_mask) | req_ready;
    end
  end

endmodule

// File: tb/tb_float_conv_arbiter.sv
// Bench for float_conv_arbiter: behavioural LAT-cycle converter, a per-cycle
// reference model of the arbitration/response rules, and directed scenarios
// with hand-computed expectations.
module tb_float_conv_arbiter;
  import float_conv_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [DATA_W*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        busy;
  logic [NREQ-1:0]        resp_valid;
  logic [31:0]            resp_data;
  logic [31:0]            conv_a;
  logic                   conv_start;
  logic [31:0]            conv_value;
  logic [31:0]            conv_pipe [LAT];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  float_conv_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .conv_a     (conv_a),
    .conv_start (conv_start),
    .conv_value (conv_value)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Signed 32-bit integer to IEEE-754 single, round to nearest even.
  function automatic logic [31:0] int_to_float(input logic [31:0] x);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] m;
    logic [31:0] rem;
    logic [31:0] half;
    logic [7:0]  e;
    int          p;
    if (x == 32'd0) return 32'd0;
    sign = x[31];
    mag  = sign ? (~x + 32'd1) : x;
    p    = 0;
    for (int b = 0; b < 32; b++) if (mag[b]) p = b;
    e = 8'(127 + p);
    if (p <= 23) begin
      m = mag << (23 - p);
    end else begin
      m    = mag >> (p - 23);
      rem  = mag & ((32'd1 << (p - 23)) - 32'd1);
      half = 32'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m = m >> 1;
        e = e + 8'd1;
      end
    end
    return {sign, e, m[22:0]};
  endfunction

  // External converter: result for conv_a of cycle k appears in cycle k+LAT.
  always @(posedge clk) begin
    conv_pipe[0] <= int_to_float(conv_a);
    for (int i = 1; i < LAT; i++) conv_pipe[i] <= conv_pipe[i-1];
  end
  assign conv_value = conv_pipe[LAT-1];

  // Reference model: each requester has at most one operation in flight,
  // tracked by its age in cycles since acceptance (-1 = idle).
  initial begin
    int              m_age [NREQ];
    logic [31:0]     m_op [NREQ];
    int              m_ptr;
    logic [31:0]     m_conv_a;
    logic [31:0]     m_resp_data;
    logic            m_start;
    logic [NREQ-1:0] exp_busy;
    logic [NREQ-1:0] exp_resp;
    logic [NREQ-1:0] exp_ready;
    int              g;
    int              idx;
    for (int i = 0; i < NREQ; i++) begin
      m_age[i] = -1;
      m_op[i]  = '0;
    end
    m_ptr = 0; m_conv_a = '0; m_resp_data = '0; m_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_conv_a", conv_a, 0);
        check("rst_conv_start", conv_start, 0);
        for (int i = 0; i < NREQ; i++) m_age[i] = -1;
        m_ptr = 0; m_conv_a = '0; m_resp_data = '0; m_start = 1'b0;
      end else begin
        exp_busy = '0;
        exp_resp = '0;
        for (int i = 0; i < NREQ; i++) begin
          if (m_age[i] >= 1 && m_age[i] <= LAT + 1) begin
            exp_busy[i] = 1'b1;
          end else if (m_age[i] == LAT + 2) begin
            exp_resp[i] = 1'b1;
            m_resp_data = int_to_float(m_op[i]);
            m_age[i]    = -1;
          end
        end
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx] && !exp_busy[idx]) g = idx;
        end
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("cmp_ready", req_ready, exp_ready);
        check("cmp_busy", busy, exp_busy);
        check("cmp_resp_valid", resp_valid, exp_resp);
        check("cmp_resp_data", resp_data, m_resp_data);
        check("cmp_conv_a", conv_a, m_conv_a);
        check("cmp_conv_start", conv_start, m_start);
        m_start = (g >= 0);
        if (g >= 0) begin
          m_conv_a = req_data[g*32 +: 32];
          m_op[g]  = m_conv_a;
          m_age[g] = 0;
          m_ptr    = (g + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) if (m_age[i] >= 0) m_age[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d);
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  t5_ready [10];
    logic [31:0] t3_float [4];
    logic [3:0]  t7_valid [8];
    logic [31:0] t7_ops [8];

    t3_float = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    t5_ready = '{4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b1000,
                 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    t7_valid = '{4'b1111, 4'b0101, 4'b1010, 4'b0011,
                 4'b1100, 4'b0001, 4'b1111, 4'b0000};
    t7_ops   = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                 32'h7FFFFFFF, 32'd16777217, 32'd16777219, 32'd123456789};

    // Reset state.
    tick();
    tick();
    check("reset_busy", busy, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_conv_start", conv_start, 0);
    reset_n = 1'b1;
    tick();

    // Single request, operand 49.
    req_valid = 4'b0001;
    set_req(0, 32'd49);
    #1 check("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("t1_conv_start", conv_start, 1);
    check("t1_conv_a", conv_a, 32'd49);
    check("t1_busy", busy, 4'b0001);
    tick();
    tick();
    check("t1_no_early_resp", resp_valid, 0);
    tick();
    check("t1_resp_valid", resp_valid, 4'b0001);
    check("t1_resp_data", resp_data, 32'h42440000);
    check("t1_busy_clear", busy, 0);
    tick();
    check("t1_resp_pulse", resp_valid, 0);
    check("t1_resp_hold", resp_data, 32'h42440000);

    // Negative operand on requester 2.
    req_valid = 4'b0100;
    set_req(2, 32'hFFFFFFF9);
    #1 check("t2_ready", req_ready, 4'b0100);
    for (int c = 1; c <= 4; c++) begin
      tick();
      req_valid = '0;
      if (c == 4) begin
        check("t2_resp_valid", resp_valid, 4'b0100);
        check("t2_resp_data", resp_data, 32'hC0E00000);
      end
    end
    tick();

    // All four requesters at once from ptr=0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1));
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 4) ? (4'b1111 << k) : 4'b0000;
      #1;
      if (k < 4) check("t3_ready", req_ready, 4'b0001 << k);
      else begin
        check("t3_resp_valid", resp_valid, 4'b0001 << (k - 4));
        check("t3_resp_data", resp_data, t3_float[k-4]);
      end
      tick();
    end
    req_valid = 4'b1111;
    #1 check("t3_ptr_wrapped", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // Requester 1 holds req_valid: re-granted only in its response cycle.
    req_valid = 4'b0010;
    set_req(1, 32'd1000);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) req_valid = '0;
      #1;
      check("t4_ready", req_ready, (k == 0 || k == 4) ? 4'b0010 : 4'b0000);
      if (k == 4) check("t4_resp_valid", resp_valid, 4'b0010);
      tick();
    end
    repeat (5) tick();

    // Requesters 1 and 3 continuously with ptr=2: order 3,1,3,1.
    set_req(1, 32'hFFFFFFFF);
    set_req(3, 32'd100);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) req_valid = 4'b1010;
      if (k == 6) req_valid = '0;
      #1;
      check("t5_ready", req_ready, t5_ready[k]);
      if (k == 4 || k == 8) begin
        check("t5_resp3", resp_valid, 4'b1000);
        check("t5_data3", resp_data, 32'h42C80000);
      end
      if (k == 5 || k == 9) begin
        check("t5_resp1", resp_valid, 4'b0010);
        check("t5_data1", resp_data, 32'hBF800000);
      end
      tick();
    end
    repeat (3) tick();

    // Reset with two operations in flight.
    req_valid = 4'b0001;
    set_req(0, 32'd5);
    tick();
    req_valid = 4'b0100;
    set_req(2, 32'd100);
    tick();
    req_valid = 4'b1111;
    reset_n = 1'b0;
    #1;
    check("t6_ready", req_ready, 0);
    check("t6_busy", busy, 0);
    check("t6_conv_a", conv_a, 0);
    check("t6_conv_start", conv_start, 0);
    tick();
    req_valid = '0;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_no_stale_resp", resp_valid, 0);
    end
    req_valid = 4'b1000;
    set_req(3, 32'h7FFFFFFF);
    #1 check("t6_fresh_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    repeat (3) tick();
    check("t6_fresh_resp", resp_valid, 4'b1000);
    check("t6_fresh_data", resp_data, 32'h4F000000);
    tick();

    // Mixed stream with boundary operands; reference model checks every cycle.
    for (int k = 0; k < 8; k++) begin
      req_valid = t7_valid[k];
      for (int i = 0; i < NREQ; i++) set_req(i, t7_ops[(k * NREQ + i) % 8]);
      tick();
    end
    req_valid = '0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
